mxv_result_ser: RTL

MXV_RESULT_SER -- requirements
Module: mxv_result_ser

---
 rtl/mxv_pkg.sv | 16 +
 rtl/mxv_argmax_acc.sv | 34 +++
 rtl/mxv_result_ser.sv | 103 ++++++++++
 3 files changed

// File: rtl/mxv_pkg.sv
// Shared defaults, index type and serializer state encoding for the mxv result path.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mxv_pkg;

    localparam int MXV_N  = 5;
    localparam int MXV_DW = 32;
    localparam int MXV_IW = (MXV_N > 1) ? $clog2(MXV_N) : 1;

    typedef logic [MXV_IW-1:0] idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/mxv_argmax_acc.sv
// Running argmax over a beat stream; strict greater-than replaces, so ties keep the lower index.
// Latency: result and max_valid registered one cycle after the last beat. Backpressure: none, follows beat_vld.
module mxv_argmax_acc #(
    parameter int IW = 3,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat_vld,
    input  logic                 beat_first,
    input  logic                 beat_last,
    input  logic [IW-1:0]        beat_idx,
    input  logic signed [DW-1:0] beat_dat,
    output logic                 max_valid,
    output logic [IW-1:0]        max_idx,
    output logic signed [DW-1:0] max_val
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_valid <= 1'b0;
            max_idx   <= '0;
            max_val   <= '0;
        end else begin
            max_valid <= beat_vld && beat_last;
            // Beat 0 seeds the max regardless of the previous vector's result.
            if (beat_vld && (beat_first || (beat_dat > max_val))) begin
                max_idx <= beat_idx;
                max_val <= beat_dat;
            end
        end
    end

endmodule

// File: rtl/mxv_result_ser.sv
// Serializes a captured N-element result vector into beats and reports its argmax; MXV_RELU_EN clamps negatives at capture.
// Latency: first beat valid the cycle after capture, max_valid one cycle after the last beat. Backpressure: out_ready stalls beats, in_ready low while streaming.
module mxv_result_ser
    import mxv_pkg::*;
#(
    parameter int N  = MXV_N,
    parameter int DW = MXV_DW,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data [N],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [IW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 max_valid,
    output logic [IW-1:0]        max_idx,
    output logic signed [DW-1:0] max_val
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t               state;
    logic [IW-1:0]        cnt;
    logic [IW-1:0]        cnt_nxt;
    logic signed [DW-1:0] buf_q [N];
    logic                 beat_acc;

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x);
`ifdef MXV_RELU_EN
        return (x < 0) ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign cnt_nxt  = cnt + IW'(1);
    assign beat_acc = out_valid && out_ready;
    assign out_idx  = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) buf_q[i] <= relu(in_data[i]);
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= relu(in_data[0]);
                        out_last  <= (N == 1);
                        in_ready  <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    // in_valid is deliberately not looked at here; one vector in flight at a time.
                    if (beat_acc) begin
                        if (cnt == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt      <= cnt_nxt;
                            out_data <= buf_q[cnt_nxt];
                            out_last <= (cnt_nxt == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mxv_argmax_acc #(
        .IW(IW),
        .DW(DW)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .beat_vld   (beat_acc),
        .beat_first (cnt == '0),
        .beat_last  (out_last),
        .beat_idx   (cnt),
        .beat_dat   (out_data),
        .max_valid  (max_valid),
        .max_idx    (max_idx),
        .max_val    (max_val)
    );

endmodule
